// File: rtl/spi_frame_rx.sv
// SPI-slave frame receiver: oversamples the SPI pins on the system clock,
// assembles fixed-length frames and reports short, long and stalled frames.
module spi_frame_rx #(
  parameter int c_frame_bits     = 128,
  parameter int c_sync_stages    = 2,
  parameter int c_cpol           = 0,
  parameter int c_msb_first      = 1,
  parameter int c_timeout_cycles = 4000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_dck,
  input  logic                    i_cs,
  input  logic                    i_mosi,
  output logic [c_frame_bits-1:0] o_data,
  output logic                    o_valid,
  output logic [1:0]              o_err,
  output logic                    o_err_stb,
  output logic                    o_busy
);

  // Widths: the bit counter must hold c_frame_bits+1 (the "too long" marker),
  // the timer must hold c_timeout_cycles, the flush counter c_sync_stages+1.
  localparam int CW    = $clog2(c_frame_bits + 2);
  localparam int TW    = (c_timeout_cycles < 2) ? 1 : $clog2(c_timeout_cycles + 1);
  localparam int FW    = $clog2(c_sync_stages + 2);
  localparam int FLUSH = c_sync_stages + 1;

  localparam logic IDLE_DCK   = (c_cpol != 0);
  localparam logic TIMEOUT_EN = (c_timeout_cycles != 0);
  localparam logic MSB_FIRST  = (c_msb_first != 0);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    RECV
  } state_t;

  state_t state, state_nxt;

  logic [c_sync_stages-1:0] cs_sync, dck_sync, mosi_sync;
  logic                     cs_cur, cs_prev, dck_cur, dck_prev, mosi_cur;
  logic [FW-1:0]            flush_cnt;
  logic                     primed;

  logic [c_frame_bits-1:0]  shift_reg, shift_nxt;
  logic [CW-1:0]            bit_cnt, cnt_nxt;
  logic [TW-1:0]            timer, timer_nxt;
  logic [c_frame_bits-1:0]  data_nxt;
  logic [1:0]               err_nxt;
  logic                     valid_nxt, err_stb_nxt;

  logic sample_edge, cs_rise, cs_fall;

  // Synchronise the asynchronous pins, then register once more so edges are
  // found by comparing two clean, already-synchronised samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cs_sync   <= {c_sync_stages{1'b1}};
      dck_sync  <= {c_sync_stages{IDLE_DCK}};
      mosi_sync <= '0;
      cs_cur    <= 1'b1;
      cs_prev   <= 1'b1;
      dck_cur   <= IDLE_DCK;
      dck_prev  <= IDLE_DCK;
      mosi_cur  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[c_sync_stages-2:0], i_cs};
      dck_sync  <= {dck_sync[c_sync_stages-2:0], i_dck};
      mosi_sync <= {mosi_sync[c_sync_stages-2:0], i_mosi};
      cs_cur    <= cs_sync[c_sync_stages-1];
      cs_prev   <= cs_cur;
      dck_cur   <= dck_sync[c_sync_stages-1];
      dck_prev  <= dck_cur;
      mosi_cur  <= mosi_sync[c_sync_stages-1];
    end
  end

  // After reset the synchronisers hold idle values, not the pins; wait until
  // the pin levels have reached cs_cur before trusting "cs is high".
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      flush_cnt <= '0;
    end else if (!primed) begin
      flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign primed      = (flush_cnt == FW'(FLUSH));
  assign sample_edge = (dck_cur != dck_prev) && (dck_cur != IDLE_DCK);
  assign cs_rise     = cs_cur & ~cs_prev;
  assign cs_fall     = ~cs_cur & cs_prev;
  assign o_busy      = (state == RECV);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus frame assembly; a sample in the same cycle as the
  // cs rise is folded in before the frame length is judged.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    cnt_nxt     = bit_cnt;
    timer_nxt   = timer;
    data_nxt    = o_data;
    err_nxt     = o_err;
    valid_nxt   = 1'b0;
    err_stb_nxt = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (primed && cs_cur) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          shift_nxt = '0;
          cnt_nxt   = '0;
          timer_nxt = '0;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (sample_edge) begin
          if (bit_cnt < CW'(c_frame_bits)) begin
            if (MSB_FIRST) begin
              shift_nxt = {shift_reg[c_frame_bits-2:0], mosi_cur};
            end else begin
              shift_nxt = {mosi_cur, shift_reg[c_frame_bits-1:1]};
            end
          end
          if (bit_cnt <= CW'(c_frame_bits)) begin
            cnt_nxt = bit_cnt + 1'b1;
          end
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
        if (cs_rise) begin
          state_nxt = IDLE;
          if (cnt_nxt == CW'(c_frame_bits)) begin
            valid_nxt = 1'b1;
            data_nxt  = shift_nxt;
          end else if (cnt_nxt < CW'(c_frame_bits)) begin
            err_stb_nxt = 1'b1;
            err_nxt     = 2'b01;
          end else begin
            err_stb_nxt = 1'b1;
            err_nxt     = 2'b10;
          end
        end else if (TIMEOUT_EN && !sample_edge && (timer == TW'(c_timeout_cycles))) begin
          err_stb_nxt = 1'b1;
          err_nxt     = 2'b11;
          state_nxt   = WAIT_IDLE;
        end
      end
      default: begin
        state_nxt = WAIT_IDLE;
      end
    endcase
  end

  // Datapath and output registers; o_data and o_err hold between strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      timer     <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_err     <= 2'b00;
      o_err_stb <= 1'b0;
    end else begin
      shift_reg <= shift_nxt;
      bit_cnt   <= cnt_nxt;
      timer     <= timer_nxt;
      o_data    <= data_nxt;
      o_valid   <= valid_nxt;
      o_err     <= err_nxt;
      o_err_stb <= err_stb_nxt;
    end
  end

endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
Parametrised SPI-slave frame receiver; successor to the fixed 128-bit front end of the lamp controller.
- Oversamples i_dck / i_cs / i_mosi on the system clock.
- Assembles frames of configurable length and bit order.
- Publishes each complete frame on a held parallel output with a one-cycle valid strobe.
- Reports short, long and stalled frames instead of silently accepting them.
- Sits between the host SPI pins and the LED-driver serialiser.

Parameters:
c_frame_bits, 128, bits per frame (>=8)
c_sync_stages, 2, synchroniser flops on each SPI input (>=2)
c_cpol, 0, 0: sample on i_dck rising edge; 1: sample on falling edge
c_msb_first, 1, 1: first bit received lands in o_data[c_frame_bits-1]; 0: lands in o_data[0]
c_timeout_cycles, 4000, i_clk cycles without a sample edge while selected before abort; 0 disables

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_dck  in  1  SPI clock, asynchronous to i_clk
i_cs  in  1  SPI chip select, active-low, asynchronous
i_mosi  in  1  SPI data, asynchronous
o_data  out  c_frame_bits  last good frame, held until the next good frame
o_valid  out  1  one-cycle pulse: o_data updated this cycle
o_err  out  2  error code, valid when o_err_stb=1: 01 short, 10 long, 11 timeout
o_err_stb  out  1  one-cycle error pulse
o_busy  out  1  high while a frame is being received (state RECV)

Behaviour:
- Reset is asynchronous and active-high on i_rst; i_clk is the only clock.
- Reset values: o_data=0, o_valid=0, o_err=00, o_err_stb=0, o_busy=0; synchronisers reset to idle levels (cs=1, dck=c_cpol, mosi=0); state WAIT_IDLE.
- Synchronisation: each input passes through c_sync_stages flops. Edges are detected on the synchronised signals (previous vs current), never on raw pins.
- Sample edge: synchronised dck transitions toward the non-idle level (0->1 when c_cpol=0, 1->0 when c_cpol=1). The bit taken is synchronised mosi in the same cycle.
- States:
  - WAIT_IDLE: ignore everything until synced cs=1, then go to IDLE. Reset released while cs is low therefore drops the partial frame with no error.
  - IDLE: on synced cs falling edge, clear shift register, bit_cnt=0, timer=0, go to RECV.
  - RECV, o_busy=1:
    - Each sample edge: shift bit in per c_msb_first, bit_cnt+1 saturating at c_frame_bits+1, timer cleared.
    - Bits beyond c_frame_bits are discarded; the shift register keeps the first c_frame_bits bits.
    - timer increments each cycle without a sample edge.
  - cs rising edge in RECV: evaluate and go to IDLE.
    - A sample edge detected in the same cycle is counted first.
    - bit_cnt==c_frame_bits: next cycle o_data<=shift register, o_valid=1.
    - bit_cnt<c_frame_bits: next cycle o_err=01, o_err_stb=1.
    - bit_cnt>c_frame_bits: next cycle o_err=10, o_err_stb=1.
    - o_data is unchanged on any error.
  - Timeout in RECV: when c_timeout_cycles!=0 and timer reaches c_timeout_cycles, next cycle o_err=11, o_err_stb=1, go to WAIT_IDLE.
- Latency: o_valid rises exactly c_sync_stages+2 i_clk cycles after i_cs goes high at the pin (aligned to i_clk). No other latency is allowed.
- o_valid and o_err_stb are never high in the same cycle. o_err holds its last code between strobes.
- Input constraint: i_dck period >= 8 i_clk periods. A zero-bit frame (cs low then high, no edges) produces a short error.

Test Plan:
- Good frame: c_frame_bits=128, 20 MHz clk, 100 kHz dck, MSB first, 0x000e0078001001001001800800800800 -> single o_valid; o_data equals that value; o_err_stb never asserted.
- Bit order: same frame with c_msb_first=0 -> o_data == bit-reverse(0x000e0078001001001001800800800800).
- Short and long frames: 127 bits -> o_err=01 pulse, o_data still holds the previous frame. 130 bits -> o_err=10 pulse, o_data unchanged.
- Timeout: c_timeout_cycles=4000, cs low, 10 bits sent, dck stops for 5000 cycles -> o_err=11 at stall cycle 4001. Later cs rise gives no strobe; next good frame is accepted.
- Reset mid-frame: i_rst pulsed after 60 bits, cs held low, 68 more bits, then cs high -> no o_valid, no o_err_stb. Following full frame gives o_valid.
- c_cpol=1 with inverted dck, and back-to-back frames with 2 us cs-high gap -> two o_valid pulses, each o_data correct, and each o_valid exactly c_sync_stages+2 cycles after its cs rise.
